// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch / PC sequencing driven by four-phase clock
//            levels. Optional phase-order checking via FETCH_SEQ_CHECK_EN.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter int         PC_W   = 8,
    parameter int         IR_W   = 15,
    parameter logic [3:0] HLT_OP = 4'hF
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            CLK_FT,
    input  logic            CLK_DC,
    input  logic            CLK_EX,
    input  logic            CLK_WB,
    input  logic [IR_W-1:0] ROM_DATA,
    input  logic            BR_TAKEN,
    input  logic [PC_W-1:0] BR_ADDR,
    output logic [PC_W-1:0] ROM_ADDR,
    output logic [PC_W-1:0] PC,
    output logic [IR_W-1:0] IR,
    output logic            IR_VALID,
    output logic            STB_DC,
    output logic            STB_EX,
    output logic            STB_WB,
    output logic            HALTED,
    output logic            SEQ_ERR
);

    typedef enum logic [2:0] {
        S_FT   = 3'd0,
        S_DC   = 3'd1,
        S_EX   = 3'd2,
        S_WB   = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t          r_state;
    logic [3:0]      r_prev;
    logic [PC_W-1:0] r_pc;
    logic [IR_W-1:0] r_ir;
    logic            r_ir_valid;
    logic            r_stb_dc;
    logic            r_stb_ex;
    logic            r_stb_wb;
    logic            r_halted;

    logic [3:0]      w_phase;
    logic [3:0]      w_edge;
    logic [3:0]      w_expect;
    logic            w_accept;
    logic [3:0]      w_opcode;

    assign w_phase  = {CLK_WB, CLK_EX, CLK_DC, CLK_FT};
    assign w_edge   = w_phase & ~r_prev;
    assign w_opcode = r_ir[IR_W-1 -: 4];

    // One-hot mask of the phase edge the sequencer is waiting for.
    always_comb begin
        w_expect = 4'b0000;
        case (r_state)
            S_FT:    w_expect = 4'b0001;
            S_DC:    w_expect = 4'b0010;
            S_EX:    w_expect = 4'b0100;
            S_WB:    w_expect = 4'b1000;
            default: w_expect = 4'b0000;
        endcase
    end

    assign w_accept = |(w_edge & w_expect);

`ifdef FETCH_SEQ_CHECK_EN
    logic r_seq_err;
    logic w_ooo;
    assign w_ooo   = (r_state != S_HALT) && (|(w_edge & ~w_expect));
    assign SEQ_ERR = r_seq_err;
`else
    assign SEQ_ERR = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= S_FT;
            r_prev     <= 4'b0000;
            r_pc       <= '0;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_stb_dc   <= 1'b0;
            r_stb_ex   <= 1'b0;
            r_stb_wb   <= 1'b0;
            r_halted   <= 1'b0;
`ifdef FETCH_SEQ_CHECK_EN
            r_seq_err  <= 1'b0;
`endif
        end else begin
            r_prev   <= w_phase;
            r_stb_dc <= 1'b0;
            r_stb_ex <= 1'b0;
            r_stb_wb <= 1'b0;
`ifdef FETCH_SEQ_CHECK_EN
            if (w_ooo) begin
                r_seq_err <= 1'b1;
            end
`endif
            if (w_accept) begin
                case (r_state)
                    S_FT: begin
                        r_ir       <= ROM_DATA;
                        r_ir_valid <= 1'b1;
                        r_state    <= S_DC;
                    end
                    S_DC: begin
                        r_stb_dc <= 1'b1;
                        r_state  <= S_EX;
                    end
                    S_EX: begin
                        r_stb_ex <= 1'b1;
                        r_state  <= S_WB;
                    end
                    S_WB: begin
                        r_stb_wb <= 1'b1;
                        // Halt outranks a simultaneous taken branch.
                        if (w_opcode == HLT_OP) begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else if (BR_TAKEN) begin
                            r_pc    <= BR_ADDR;
                            r_state <= S_FT;
                        end else begin
                            r_pc    <= r_pc + PC_W'(1);
                            r_state <= S_FT;
                        end
                    end
                    default: r_state <= S_HALT;
                endcase
            end
        end
    end

    assign ROM_ADDR = r_pc;
    assign PC       = r_pc;
    assign IR       = r_ir;
    assign IR_VALID = r_ir_valid;
    assign STB_DC   = r_stb_dc;
    assign STB_EX   = r_stb_ex;
    assign STB_WB   = r_stb_wb;
    assign HALTED   = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

    logic        CLK;
    logic        RESET;
    logic [3:0]  phs;
    logic        BRT;
    logic [7:0]  BRA;
    logic [14:0] ROM_DATA;
    logic [7:0]  ROM_ADDR;
    logic [7:0]  PC;
    logic [14:0] IR;
    logic        IR_VALID, STB_DC, STB_EX, STB_WB, HALTED, SEQ_ERR;

    logic [14:0] rom [256];
    assign ROM_DATA = rom[ROM_ADDR];

    fetch_unit #(.PC_W(8), .IR_W(15), .HLT_OP(4'hF)) dut (
        .CLK(CLK), .RESET(RESET),
        .CLK_FT(phs[0]), .CLK_DC(phs[1]), .CLK_EX(phs[2]), .CLK_WB(phs[3]),
        .ROM_DATA(ROM_DATA), .BR_TAKEN(BRT), .BR_ADDR(BRA),
        .ROM_ADDR(ROM_ADDR), .PC(PC), .IR(IR), .IR_VALID(IR_VALID),
        .STB_DC(STB_DC), .STB_EX(STB_EX), .STB_WB(STB_WB),
        .HALTED(HALTED), .SEQ_ERR(SEQ_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int compared = 0;
    int mismatched = 0;
    bit chk_on = 0;
    int n_dc, n_ex, n_wb;

    // Behavioural model: phase index 0..3 is the phase the CPU is waiting for.
    int          m_phase;
    bit          m_halt, m_seq, m_valid;
    bit [3:0]    m_prev, m_stb;
    logic [7:0]  m_pc;
    logic [14:0] m_ir;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_halt = 0; m_seq = 0; m_valid = 0;
        m_prev = 0; m_stb = 0; m_pc = 0; m_ir = 0;
    endtask

    task automatic model_update();
        bit [3:0] e;
        e = phs & ~m_prev;
        m_prev = phs;
        m_stb = 0;
        if (!m_halt) begin
`ifdef FETCH_SEQ_CHECK_EN
            for (int j = 0; j < 4; j++)
                if (e[j] && j != m_phase) m_seq = 1;
`endif
            if (e[m_phase]) begin
                if (m_phase == 0) begin
                    m_ir = rom[m_pc];
                    m_valid = 1;
                end else begin
                    m_stb[m_phase] = 1;
                end
                if (m_phase == 3) begin
                    if (m_ir[14:11] == 4'hF) m_halt = 1;
                    else if (BRT)            m_pc = BRA;
                    else                     m_pc = m_pc + 8'd1;
                end
                if (!m_halt) m_phase = (m_phase + 1) % 4;
            end
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        #1;
        if (chk_on) begin
            check("PC", PC, m_pc);
            check("ROM_ADDR", ROM_ADDR, m_pc);
            check("IR", IR, m_ir);
            check("IR_VALID", IR_VALID, m_valid);
            check("STB_DC", STB_DC, m_stb[1]);
            check("STB_EX", STB_EX, m_stb[2]);
            check("STB_WB", STB_WB, m_stb[3]);
            check("HALTED", HALTED, m_halt);
            check("SEQ_ERR", SEQ_ERR, m_seq);
            n_dc += int'(STB_DC);
            n_ex += int'(STB_EX);
            n_wb += int'(STB_WB);
        end
    end

    task automatic step(input logic [3:0] ph, input logic br, input logic [7:0] ba);
        phs = ph; BRT = br; BRA = ba;
        @(posedge CLK);
        model_update();
        @(negedge CLK);
        #2;
    endtask

    task automatic instr(input int width, input logic br, input logic [7:0] ba);
        for (int p = 0; p < 4; p++)
            for (int w = 0; w < width; w++)
                step(4'b0001 << p, (p == 3) ? br : 1'b0, ba);
    endtask

    task automatic do_reset();
        #1 RESET = 1'b1;
        model_reset();
        #1;
        check("rst_PC", PC, 8'h00);
        check("rst_IR", IR, 15'h0000);
        check("rst_flags", {IR_VALID, STB_DC, STB_EX, STB_WB, HALTED, SEQ_ERR}, 6'b0);
        @(negedge CLK);
        #3 RESET = 1'b0;
    endtask

    task automatic clr_cnt();
        n_dc = 0; n_ex = 0; n_wb = 0;
    endtask

    initial begin
        RESET = 1'b1; phs = 0; BRT = 0; BRA = 0;
        model_reset(); clr_cnt();
        for (int i = 0; i < 256; i++)
            rom[i] = {4'($urandom_range(0, 14)), 11'($urandom)};
        rom[0]  = 15'h0123;
        rom[64] = 15'h1234;
        @(negedge CLK); #2;
        chk_on = 1;
        do_reset();

        // First fetch
        step(4'b0001, 0, 0);
        check("first_IR", IR, 15'h0123);
        check("first_VALID", IR_VALID, 1'b1);
        step(4'b0010, 0, 0); step(4'b0100, 0, 0); step(4'b1000, 0, 0);
        step(4'b0000, 0, 0);
        check("first_PC", PC, 8'h01);
        check("first_strobes", {8'(n_dc), 8'(n_ex), 8'(n_wb)}, 24'h010101);

        // Wrap-around 8'hFF -> 8'h00
        for (int i = 0; i < 255; i++) instr(1, 0, 0);
        check("wrap_PC", PC, 8'h00);
        step(4'b0001, 0, 0);
        check("wrap_IR", IR, 15'h0123);
        step(4'b0010, 0, 0); step(4'b0100, 0, 0); step(4'b1000, 0, 0);

        // Branch at WB, then branch request during DC only
        instr(1, 1, 8'h40);
        check("br_PC", PC, 8'h40);
        step(4'b0001, 0, 0);
        check("br_IR", IR, 15'h1234);
        step(4'b0010, 1, 8'h10); step(4'b0100, 0, 0); step(4'b1000, 0, 0);
        check("br_dc_only_PC", PC, 8'h41);

        // Halt
        rom[2] = 15'h7800;
        do_reset();
        instr(1, 0, 0); instr(1, 0, 0); instr(1, 1, 8'h20);
        check("halt_HALTED", HALTED, 1'b1);
        check("halt_PC", PC, 8'h02);
        clr_cnt();
        instr(1, 0, 0); instr(2, 1, 8'h33);
        check("halt_nostb", {8'(n_dc), 8'(n_ex), 8'(n_wb)}, 24'h0);
        check("halt_PC2", PC, 8'h02);
        check("halt_IR", IR, 15'h7800);

        // Out-of-order EX edge while waiting for DC
        do_reset();
        clr_cnt();
        step(4'b0001, 0, 0);
        step(4'b0100, 0, 0);
`ifdef FETCH_SEQ_CHECK_EN
        check("ooo_SEQ_ERR", SEQ_ERR, 1'b1);
`else
        check("ooo_SEQ_ERR", SEQ_ERR, 1'b0);
`endif
        check("ooo_noEX", STB_EX, 1'b0);
        step(4'b0010, 0, 0);
        step(4'b0000, 0, 0);
        check("ooo_dc_ok", {8'(n_dc), 8'(n_ex)}, 16'h0100);

        // Reset asserted in S_EX mid-cycle
        do_reset();
        step(4'b0001, 0, 0); step(4'b0010, 0, 0);
        do_reset();

        // Wide phases: exactly one strobe each
        clr_cnt();
        instr(3, 0, 0);
        step(4'b0000, 0, 0);
        check("wide_strobes", {8'(n_dc), 8'(n_ex), 8'(n_wb)}, 24'h010101);
        check("wide_PC", PC, 8'h01);

        // Randomized phases, branches and resets
        for (int i = 0; i < 256; i++)
            rom[i] = 15'($urandom);
        for (int i = 0; i < 4000; i++) begin
            int r;
            logic [3:0] ph;
            r = $urandom_range(0, 5);
            if (r < 3)       ph = 4'b0001 << m_phase;
            else if (r == 3) ph = 4'b0000;
            else             ph = 4'($urandom);
            if ((m_halt && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0)
                do_reset();
            step(ph, 1'($urandom), 8'($urandom));
        end

        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and PC sequencing stage of the 15-bit CPU, directly downstream of the four-phase clock generator. Samples the generator's FT/DC/EX/WB phase outputs as level inputs in the `CLK` domain. Advances a four-state phase FSM on their rising edges. Per instruction, it:
- drives the ROM address;
- latches the 15-bit instruction;
- emits per-phase enable strobes to the decode/execute/writeback logic;
- updates the PC with increment, branch or halt.

## Interface
Parameters:
- `PC_W`, 8: program counter / ROM address width.
- `IR_W`, 15: instruction width.
- `HLT_OP`, 4'hF: opcode value (`IR[IR_W-1 -: 4]`) that halts the CPU.

Ports (one clock; reset is asynchronous and active-high):
- `CLK` in 1: system clock; all state changes on its rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `CLK_FT` in 1: fetch phase level from clock generator.
- `CLK_DC` in 1: decode phase level.
- `CLK_EX` in 1: execute phase level.
- `CLK_WB` in 1: writeback phase level.
- `ROM_DATA` in `IR_W`: combinational ROM read data for `ROM_ADDR`.
- `BR_TAKEN` in 1: branch taken, from the execute stage.
- `BR_ADDR` in `PC_W`: branch target.
- `ROM_ADDR` out `PC_W`: equals `PC`.
- `PC` out `PC_W`: current program counter.
- `IR` out `IR_W`: latched instruction.
- `IR_VALID` out 1: `IR` holds a fetched instruction.
- `STB_DC` out 1: one-cycle decode enable.
- `STB_EX` out 1: one-cycle execute enable.
- `STB_WB` out 1: one-cycle writeback enable.
- `HALTED` out 1: sticky halt indicator.
- `SEQ_ERR` out 1: sticky phase-order error.

## Operation
- **Edge detection:** the block registers the previous value of each phase input. `edge_X = CLK_X & ~prev_X`. Each action occurs on the `CLK` edge at which `edge_X` is first seen.
- **FSM states:** `S_FT` (expect FT), `S_DC`, `S_EX`, `S_WB`, `S_HALT`.
- **`S_FT`, on `edge_FT`:**
  - `IR <= ROM_DATA` (address = current `PC`).
  - `IR_VALID <= 1`.
  - Next state `S_DC`.
- **`S_DC`, on `edge_DC`:** `STB_DC` pulses one cycle. Next state `S_EX`.
- **`S_EX`, on `edge_EX`:** `STB_EX` pulses one cycle. Next state `S_WB`.
- **`S_WB`, on `edge_WB`:** `STB_WB` pulses one cycle, then:
  - if opcode == `HLT_OP`: `PC` unchanged, `HALTED <= 1`, next state `S_HALT`;
  - else if `BR_TAKEN`: `PC <= BR_ADDR`, next state `S_FT`;
  - else `PC <= PC + 1`, next state `S_FT`.
- **PC wrap:** increment is modulo 2^`PC_W`, so 8'hFF → 8'h00.
- **`S_HALT`:** absorbing state. All edges are ignored, no strobes are issued, and `PC`/`IR` are frozen. Only `RESET` exits.
- **Out-of-order edges:** an edge of any phase other than the expected one is ignored, and state does not change.
- **Simultaneous edges:** if the expected edge is present, it is accepted. Any other simultaneous edges are treated as out-of-order.
- **`BR_TAKEN` without `edge_WB` in `S_WB`:** has no effect.
- **`BR_TAKEN` on an HLT instruction:** halt takes priority over the branch.

## Timing
- **Reset values** (asynchronous, take effect immediately on `RESET` high):
  - `PC` = 0, `ROM_ADDR` = 0, `IR` = 0.
  - `IR_VALID` = 0, `STB_*` = 0, `HALTED` = 0, `SEQ_ERR` = 0.
  - State = `S_FT`, all `prev_X` = 0.
- **Phase held high at reset release:** a phase input already high when `RESET` deasserts counts as an edge on the first `CLK`.
- **Edge-to-action latency:** a phase input that rises before `CLK` edge N is detected at edge N, and its registered action is visible after edge N.
- **Strobes:** each `STB_*` is high for exactly one `CLK` cycle per accepted edge, regardless of phase width.
- **ROM timing:** `ROM_ADDR` changes only after an accepted WB edge. `ROM_DATA` must be valid at the next accepted FT edge.
- **Reset mid-instruction:** aborts the instruction. After reset release, fetch restarts from address 0.

## Configuration
- **`FETCH_SEQ_CHECK_EN` defined:**
  - Every out-of-order edge sets `SEQ_ERR` on that `CLK` edge; it stays 1 until `RESET`.
  - Edges arriving while in `S_HALT` do not set `SEQ_ERR`.
- **`FETCH_SEQ_CHECK_EN` undefined:**
  - `SEQ_ERR` is tied to 0.
  - Out-of-order edges are still ignored.
  - All other behaviour is identical.

## Test plan
- **Reset and first fetch:**
  - Stimulus: `RESET` pulse; ROM[0] = 15'h0123; phases cycle FT, DC, EX, WB, each high 1 `CLK`.
  - Required: `IR` = 15'h0123 and `IR_VALID` = 1 after the FT edge; one pulse each on `STB_DC`/`STB_EX`/`STB_WB`; `PC` = 1 after the WB edge.
- **Wrap-around:**
  - Stimulus: run 256 non-branch instructions.
  - Required: `PC` goes 8'hFF → 8'h00, and `IR` reloads from ROM[0].
- **Branch:**
  - Stimulus: `BR_TAKEN` = 1 and `BR_ADDR` = 8'h40 at the WB edge.
  - Required: `PC` = 8'h40, and the next FT edge latches ROM[8'h40].
  - Stimulus: `BR_TAKEN` = 1 during the DC phase only.
  - Required: no effect.
- **Halt:**
  - Stimulus: ROM[2] = 15'h7800 (opcode 4'hF).
  - Required: after its WB edge, `HALTED` = 1 and `PC` = 2; further phase edges produce no strobes and no `PC`/`IR` change.
- **Order error (macro defined):**
  - Stimulus: in `S_DC`, raise `CLK_EX`.
  - Required: `SEQ_ERR` = 1, state stays `S_DC`, no `STB_EX`; a following DC edge is accepted normally.
  - Stimulus: same, with the macro undefined.
  - Required: `SEQ_ERR` stays 0.
- **Reset mid-operation and wide phases:**
  - Stimulus: assert `RESET` in `S_EX`.
  - Required: all outputs return to reset values immediately.
  - Stimulus: phases each held high 3 `CLK` cycles.
  - Required: exactly one strobe per phase.
